// File: rtl/inst_mem_server_pkg.sv
// Shared memory-message definitions used by inst_mem_server and its clients.
//   t_op          : request/response operation (read or byte-strobed write)
//   mem_msg_t     : packed request/response message {op, opaque, addr, strb, data}
//   apply_strb    : merges strobed bytes of new data into an old word
package inst_mem_server_pkg;

  typedef enum logic [2:0] {
    MEM_MSG_READ  = 3'd0,
    MEM_MSG_WRITE = 3'd1
  } t_op;

  typedef struct packed {
    t_op         op;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_msg_t;

  localparam int MEM_MSG_W = $bits(mem_msg_t);

  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_intf.sv
// Valid/ready memory interface between a client (fetch unit etc.) and a
// memory server.
//   req_val/req_rdy/req_msg    : request channel, client -> server
//   resp_val/resp_rdy/resp_msg : response channel, server -> client
interface MemIntf;
  import inst_mem_server_pkg::*;

  logic     req_val;
  logic     req_rdy;
  mem_msg_t req_msg;
  logic     resp_val;
  logic     resp_rdy;
  mem_msg_t resp_msg;

  modport server (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );

  modport client (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

endinterface

// File: rtl/fifo_arst.sv
// Synchronous FIFO with asynchronous active-high reset.
//   clk, rst      : clock, async active-high reset (clears pointers/count)
//   push, wdata   : write request and data (ignored when full unless popping)
//   pop, rdata    : read request and head-of-queue data (valid when !empty)
//   empty, full   : occupancy flags
module fifo_arst #(
  parameter int p_width = 8,
  parameter int p_depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [p_width-1:0] wdata,
  output logic [p_width-1:0] rdata,
  output logic               empty,
  output logic               full
);

  localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);
  // Storage rounded up to a power of two so pointer indexing is always in
  // range; entries beyond p_depth are never addressed.
  localparam int SZ = 1 << AW;

  logic [p_width-1:0] store [SZ];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               do_push;
  logic               do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(p_depth));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is allowed when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_mem_server.sv
// Word-addressed memory responder on the server side of MemIntf. Reads and
// byte-strobed writes are answered in request order after a fixed latency;
// credit-based back-pressure on req_rdy guarantees no accepted request is
// ever dropped while the client stalls responses.
//   clk, rst : clock, async active-high reset (clears in-flight state only)
//   mem      : MemIntf server modport (req_* in, resp_* out)
module inst_mem_server
  import inst_mem_server_pkg::*;
#(
  parameter int p_num_words = 1024,
  parameter int p_latency   = 2,
  parameter int p_depth     = 4
) (
  input logic   clk,
  input logic   rst,
  MemIntf.server mem
);

  localparam int IW = $clog2(p_num_words);
  localparam int CW = $clog2(p_depth + 1);

  if (p_latency < 1) begin : g_chk_latency
    $error("inst_mem_server: p_latency must be at least 1");
  end
  if (p_depth < p_latency) begin : g_chk_depth
    $error("inst_mem_server: p_depth must be at least p_latency");
  end
  if ((p_num_words < 2) || ((p_num_words & (p_num_words - 1)) != 0)) begin : g_chk_words
    $error("inst_mem_server: p_num_words must be a power of two");
  end

  logic [31:0]   mem_array [p_num_words];
  logic          accept;
  logic          pop;
  logic [IW-1:0] idx;
  mem_msg_t      resp_now;
  logic          fifo_push;
  mem_msg_t      fifo_wdata;
  mem_msg_t      fifo_rdata;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] count;

  assign accept = mem.req_val & mem.req_rdy;
  assign pop    = mem.resp_val & mem.resp_rdy;
  // Upper address bits and the byte offset are dropped: addresses wrap.
  assign idx    = mem.req_msg.addr[IW+1:2];

  // Response is formed from the array contents just before the accept edge;
  // the echoed fields keep the caller's full address.
  always_comb begin
    resp_now = mem.req_msg;
    if (mem.req_msg.op == MEM_MSG_WRITE) resp_now.data = '0;
    else                                 resp_now.data = mem_array[idx];
  end

  always_ff @(posedge clk) begin
    if (accept && (mem.req_msg.op == MEM_MSG_WRITE)) begin
      for (int b = 0; b < 4; b++) begin
        if (mem.req_msg.strb[b]) mem_array[idx][8*b +: 8] <= mem.req_msg.data[8*b +: 8];
      end
    end
  end

  // Fixed-latency pipeline. Stages never stall: the outstanding-credit limit
  // reserves a FIFO slot for every request already in flight.
  if (p_latency == 1) begin : g_direct
    assign fifo_push  = accept;
    assign fifo_wdata = resp_now;
  end else begin : g_pipe
    localparam int NS = p_latency - 1;
    logic     stg_val [NS];
    mem_msg_t stg_msg [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NS; i++) stg_val[i] <= 1'b0;
      end else begin
        stg_val[0] <= accept;
        for (int i = 1; i < NS; i++) stg_val[i] <= stg_val[i-1];
      end
    end

    always_ff @(posedge clk) begin
      stg_msg[0] <= resp_now;
      for (int i = 1; i < NS; i++) stg_msg[i] <= stg_msg[i-1];
    end

    assign fifo_push  = stg_val[NS-1];
    assign fifo_wdata = stg_msg[NS-1];
  end

  fifo_arst #(
    .p_width (MEM_MSG_W),
    .p_depth (p_depth)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outstanding requests (pipeline + FIFO). A pop only frees a credit on the
  // following cycle, so req_rdy never depends on resp_rdy combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign mem.req_rdy  = ~rst & (count < CW'(p_depth));
  assign mem.resp_val = ~fifo_empty;
  assign mem.resp_msg = fifo_rdata;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_inst_mem_server.sv
module tb_inst_mem_server;
  import inst_mem_server_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  MemIntf m0 ();
  MemIntf m1 ();

  inst_mem_server #(.p_num_words(1024), .p_latency(2), .p_depth(4)) u_dut0 (
    .clk (clk), .rst (rst), .mem (m0)
  );
  inst_mem_server #(.p_num_words(64), .p_latency(1), .p_depth(1)) u_dut1 (
    .clk (clk), .rst (rst), .mem (m1)
  );

  typedef struct {
    mem_msg_t msg;
    int       ready;
    bit       dchk;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int resp_cnt [2];
  int acc_cnt  [2];
  mem_msg_t last [2];
  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  exp_t q0 [$];
  exp_t q1 [$];

  function automatic int words_of(int d); return (d == 0) ? 1024 : 64; endfunction
  function automatic int lat_of(int d);   return (d == 0) ? 2 : 1;     endfunction
  function automatic int dep_of(int d);   return (d == 0) ? 4 : 1;     endfunction

  function automatic int q_size(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
  function automatic exp_t q_front(int d); return (d == 0) ? q0[0] : q1[0]; endfunction
  function automatic void q_pop(int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void q_push(int d, exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  function automatic void q_clear(int d);
    if (d == 0) q0.delete(); else q1.delete();
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected completion (t=%0t)", name, $time);
  endtask

  // Reference memory: applied in accept order, response ready L cycles later.
  function automatic exp_t model_apply(int d, mem_msg_t rq, int now);
    exp_t e;
    logic [31:0] w;
    int idx;
    w = (rq.addr / 32'd4) % 32'(words_of(d));
    idx = int'(w);
    e.msg = rq;
    e.ready = now + lat_of(d);
    e.dchk = 1'b1;
    if (rq.op == MEM_MSG_WRITE) begin
      for (int b = 0; b < 4; b++)
        if (rq.strb[b]) mdl[d][idx][8*b +: 8] = rq.data[8*b +: 8];
      if (rq.strb == 4'hF) known[d][idx] = 1'b1;
      e.msg.data = '0;
    end else begin
      e.msg.data = mdl[d][idx];
      e.dchk = known[d][idx];
    end
    return e;
  endfunction

  task automatic mon(int d, logic rv, logic rdy, logic rsv, logic rsr,
                     mem_msg_t rq, mem_msg_t rs);
    bit exp_val;
    bit exp_rdy;
    exp_t e;
    mem_msg_t act;
    if (rst) begin
      chk($sformatf("d%0d_rst_req_rdy", d), 96'(rdy), 96'(0));
      chk($sformatf("d%0d_rst_resp_val", d), 96'(rsv), 96'(0));
      q_clear(d);
      return;
    end
    exp_val = (q_size(d) > 0) && (q_front(d).ready <= cyc);
    exp_rdy = (q_size(d) < dep_of(d));
    chk($sformatf("d%0d_resp_val", d), 96'(rsv), 96'(exp_val));
    chk($sformatf("d%0d_req_rdy", d), 96'(rdy), 96'(exp_rdy));
    if (rsv && exp_val) begin
      e = q_front(d);
      act = rs;
      if (!e.dchk) begin
        act.data = '0;
        e.msg.data = '0;
      end
      chk($sformatf("d%0d_resp_msg", d), 96'(act), 96'(e.msg));
      if (rsr) begin
        q_pop(d);
        resp_cnt[d]++;
        last[d] = rs;
      end
    end
    if (rv && exp_rdy) begin
      q_push(d, model_apply(d, rq, cyc));
      acc_cnt[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, m0.req_val, m0.req_rdy, m0.resp_val, m0.resp_rdy, m0.req_msg, m0.resp_msg);
    mon(1, m1.req_val, m1.req_rdy, m1.resp_val, m1.resp_rdy, m1.req_msg, m1.resp_msg);
    cyc++;
  end

  task automatic send0(t_op op, logic [31:0] addr, logic [3:0] strb,
                       logic [31:0] data, logic [7:0] opq);
    int n;
    m0.req_msg.op     = op;
    m0.req_msg.opaque = opq;
    m0.req_msg.addr   = addr;
    m0.req_msg.strb   = strb;
    m0.req_msg.data   = data;
    m0.req_val        = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (m0.req_rdy) break;
      n++;
      if (n > 200) begin
        tmo("send0");
        break;
      end
    end
    @(posedge clk);
    #1;
    m0.req_val = 1'b0;
  endtask

  task automatic drain(int d);
    bit done;
    if (d == 0) m0.resp_rdy = 1'b1; else m1.resp_rdy = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (q_size(d) == 0) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    if (!done) tmo($sformatf("d%0d_drain", d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    int base_r;
    int base_a;
    int sent;
    int cycles;
    bit took;

    for (int d = 0; d < 2; d++) begin
      resp_cnt[d] = 0;
      acc_cnt[d]  = 0;
      for (int i = 0; i < 1024; i++) begin
        known[d][i] = 1'b0;
        mdl[d][i]   = '0;
      end
    end
    rst = 1'b1;
    m0.req_val = 1'b0; m0.resp_rdy = 1'b0; m0.req_msg = '0;
    m1.req_val = 1'b0; m1.resp_rdy = 1'b0; m1.req_msg = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_req_rdy", 96'(m0.req_rdy), 96'(1));
    chk("post_reset_resp_val", 96'(m0.resp_val), 96'(0));
    @(posedge clk);
    #1;

    // Byte-strobed write then read-back.
    m0.resp_rdy = 1'b1;
    send0(MEM_MSG_WRITE, 32'h200, 4'b1111, 32'h11223344, 8'h01);
    send0(MEM_MSG_WRITE, 32'h200, 4'b0101, 32'hAABBCCDD, 8'h02);
    send0(MEM_MSG_READ,  32'h200, 4'b0000, 32'h0,        8'h03);
    drain(0);
    chk("model_strb_pin", 96'(mdl[0][128]), 96'(32'h11BB33DD));
    chk("strb_read_data", 96'(last[0].data), 96'(32'h11BB33DD));
    chk("strb_read_opaque", 96'(last[0].opaque), 96'(8'h03));

    // Streaming: 16 back-to-back reads, one response per cycle.
    base_r = resp_cnt[0];
    for (int i = 0; i < 16; i++)
      send0(MEM_MSG_READ, 32'h200 + 32'(4*i), 4'h0, 32'h0, 8'(8'h40 + i));
    drain(0);
    chk("stream_resp_count", 96'(resp_cnt[0] - base_r), 96'(16));
    chk("stream_last_addr", 96'(last[0].addr), 96'(32'h23C));

    // Back-pressure: exactly p_depth accepts with responses stalled.
    m0.resp_rdy = 1'b0;
    m0.req_msg.op = MEM_MSG_READ;
    m0.req_msg.addr = 32'h200;
    m0.req_msg.strb = 4'h0;
    m0.req_msg.opaque = 8'h60;
    m0.req_val = 1'b1;
    accepted = 0;
    repeat (10) begin
      @(negedge clk);
      took = m0.req_rdy;
      @(posedge clk);
      #1;
      if (took) begin
        accepted++;
        m0.req_msg.opaque = m0.req_msg.opaque + 8'd1;
      end
    end
    m0.req_val = 1'b0;
    chk("bp_accepted", 96'(accepted), 96'(4));
    m0.resp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_rdy_during_pop", 96'(m0.req_rdy), 96'(0));
    @(posedge clk);
    #1;
    m0.resp_rdy = 1'b0;
    @(negedge clk);
    chk("bp_rdy_after_pop", 96'(m0.req_rdy), 96'(1));
    chk("bp_popped_opaque", 96'(last[0].opaque), 96'(8'h60));
    @(posedge clk);
    #1;
    drain(0);

    // Address wrap: upper bits ignored, response echoes the original address.
    send0(MEM_MSG_WRITE, 32'h1000_0004, 4'hF, 32'hCAFEF00D, 8'h30);
    send0(MEM_MSG_READ,  32'h0000_0004, 4'h0, 32'h0,        8'h31);
    drain(0);
    chk("wrap_data", 96'(last[0].data), 96'(32'hCAFEF00D));
    chk("wrap_addr", 96'(last[0].addr), 96'(32'h4));

    // Reset while reads are in flight.
    send0(MEM_MSG_WRITE, 32'h200, 4'hF, 32'hDEADBEEF, 8'h50);
    drain(0);
    m0.resp_rdy = 1'b0;
    base_r = resp_cnt[0];
    send0(MEM_MSG_READ, 32'h200, 4'h0, 32'h0, 8'h51);
    send0(MEM_MSG_READ, 32'h204, 4'h0, 32'h0, 8'h52);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_rdy", 96'(m0.req_rdy), 96'(1));
    chk("rst_release_no_resp", 96'(m0.resp_val), 96'(0));
    @(posedge clk);
    #1;
    chk("rst_discarded", 96'(resp_cnt[0] - base_r), 96'(0));
    m0.resp_rdy = 1'b1;
    send0(MEM_MSG_READ, 32'h200, 4'h0, 32'h0, 8'h53);
    drain(0);
    chk("rst_array_kept", 96'(last[0].data), 96'(32'hDEADBEEF));
    chk("rst_one_resp", 96'(resp_cnt[0] - base_r), 96'(1));

    // Latency sweep on the latency-1 / depth-1 instance with random resp_rdy.
    base_r = resp_cnt[1];
    base_a = acc_cnt[1];
    sent = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      m1.resp_rdy = 1'($urandom_range(0, 1));
      if (!m1.req_val && $urandom_range(0, 3) != 0) begin
        m1.req_msg.op     = ($urandom_range(0, 1) == 0) ? MEM_MSG_READ : MEM_MSG_WRITE;
        m1.req_msg.opaque = 8'(sent);
        m1.req_msg.addr   = (32'($urandom_range(0, 15)) << 28) |
                            (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        m1.req_msg.strb   = 4'($urandom_range(0, 15));
        m1.req_msg.data   = $urandom;
        m1.req_val        = 1'b1;
      end
      @(negedge clk);
      took = m1.req_val && m1.req_rdy;
      @(posedge clk);
      #1;
      if (took) begin
        m1.req_val = 1'b0;
        sent++;
      end
      cycles++;
    end
    m1.req_val = 1'b0;
    if (sent < 1000) tmo("sweep_send");
    drain(1);
    chk("sweep_accepts", 96'(acc_cnt[1] - base_a), 96'(1000));
    chk("sweep_responses", 96'(resp_cnt[1] - base_r), 96'(1000));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
